// File: rtl/fcin.sv
// fcin: two-channel input conditioner (sync, glitch filter, power-of-two prescaler, edge strobe).
// Define FCIN_PRESCALE_EN to build the prescaler; otherwise pdv and clr are ignored.
module fcin_ch #(
  parameter int flt_size = 4,
  parameter int pre_size = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw_i,
  input  logic                clr_i,
  input  logic [flt_size-1:0] flt_i,
  input  logic [2:0]          pdv_i,
  output logic                lvl_o,
  output logic                edg_o
);
  logic s1_q, s2_q, f_q, f_d, o_q, e_q, sel, agree, fire;
  logic [flt_size-1:0] c_q, c_d;
  // >= lets a lowered threshold fire immediately instead of wrapping the counter
  always_comb begin
    agree = s2_q == f_q;
    fire = !agree && c_q >= flt_i;
    f_d = fire ? s2_q : f_q;
    c_d = agree || fire ? '0 : c_q + 1'b1;
  end
`ifdef FCIN_PRESCALE_EN
  logic [pre_size-1:0] p_q, p_d;
  logic [2:0] pk;
  always_comb begin
    pk = pdv_i > 3'(pre_size) ? 3'(pre_size) : pdv_i;
    sel = pk == 3'd0 ? f_q : p_q[pk - 3'd1];
    p_d = clr_i ? '0 : fire && s2_q ? p_q + 1'b1 : p_q;
  end
  always_ff @(posedge clk)
    p_q <= rst ? '0 : p_d;
`else
  logic unused_ok;
  assign sel = f_q;
  assign unused_ok = ^{clr_i, pdv_i, pre_size > 0};
`endif
  always_ff @(posedge clk)
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      f_q <= 1'b0;
      c_q <= '0;
      o_q <= 1'b0;
      e_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      f_q <= f_d;
      c_q <= c_d;
      o_q <= sel;
      e_q <= sel & !o_q;
    end
  assign lvl_o = o_q;
  assign edg_o = e_q;
endmodule

module fcin #(
  parameter int flt_size = 4,
  parameter int pre_size = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ina,
  input  logic                inb,
  input  logic                clr,
  input  logic [flt_size-1:0] flt,
  input  logic [2:0]          pdv,
  output logic                oua,
  output logic                oub,
  output logic                eda,
  output logic                edb
);
  fcin_ch #(.flt_size(flt_size), .pre_size(pre_size)) u_a (
    .clk(clk), .rst(rst), .raw_i(ina), .clr_i(clr), .flt_i(flt), .pdv_i(pdv),
    .lvl_o(oua), .edg_o(eda)
  );
  fcin_ch #(.flt_size(flt_size), .pre_size(pre_size)) u_b (
    .clk(clk), .rst(rst), .raw_i(inb), .clr_i(clr), .flt_i(flt), .pdv_i(pdv),
    .lvl_o(oub), .edg_o(edb)
  );
endmodule

// File: tb/tb_fcin.sv
// tb_fcin: randomized and directed checks of fcin against a history-based reference model.
module tb_fcin;
  localparam int fs = 4;
  localparam int ps = 7;
  logic clk = 1'b0, rst = 1'b1, ina = 1'b0, inb = 1'b0, clr = 1'b0;
  logic [fs-1:0] flt = '0;
  logic [2:0] pdv = '0;
  logic oua, oub, eda, edb;
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  fcin #(.flt_size(fs), .pre_size(ps)) dut (
    .clk(clk), .rst(rst), .ina(ina), .inb(inb), .clr(clr), .flt(flt), .pdv(pdv),
    .oua(oua), .oub(oub), .eda(eda), .edb(edb)
  );

  // reference: raw sample history (newest at 0); a level change is accepted once the
  // run of filter-visible samples differing from the current level exceeds flt
  bit h [2][48];
  int fm [2], pm [2], om [2], em [2];
  int run, sel;
`ifdef FCIN_PRESCALE_EN
  int pe;
  bit rf;
`endif
  always @(posedge clk)
    for (int ch = 0; ch < 2; ch++) begin
      if (rst) begin
        for (int k = 0; k < 48; k++) h[ch][k] = 1'b0;
        fm[ch] = 0; pm[ch] = 0; om[ch] = 0; em[ch] = 0;
      end else begin
`ifdef FCIN_PRESCALE_EN
        pe = int'(pdv) > ps ? ps : int'(pdv);
        sel = pe == 0 ? fm[ch] : (pm[ch] >> (pe - 1)) & 1;
`else
        sel = fm[ch];
`endif
        run = 0;
        while (run < 40 && int'(h[ch][run + 1]) != fm[ch]) run++;
`ifdef FCIN_PRESCALE_EN
        rf = run > int'(flt) && fm[ch] == 0;
        pm[ch] = clr ? 0 : rf ? (pm[ch] + 1) % (1 << ps) : pm[ch];
`endif
        if (run > int'(flt)) fm[ch] = 1 - fm[ch];
        em[ch] = (sel == 1 && om[ch] == 0) ? 1 : 0;
        om[ch] = sel;
        for (int k = 47; k > 0; k--) h[ch][k] = h[ch][k - 1];
        h[ch][0] = ch == 1 ? inb : ina;
      end
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("oua", oua, om[0]);
    chk("oub", oub, om[1]);
    chk("eda", eda, em[0]);
    chk("edb", edb, em[1]);
  endtask

  initial begin
    int ecnt, hi, t0, t1, ra, rb;
    rst = 1'b1; ina = 1'b1; inb = 1'b1;
    repeat (3) begin
      step();
      chk("rst_oua", oua, 0);
      chk("rst_eda", eda, 0);
    end
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      if (e < 4) chk("rel_early", oua, 0);
      if (e == 4) begin
        chk("rel_oua", oua, 1);
        chk("rel_oub", oub, 1);
        chk("rel_eda", eda, 1);
        chk("rel_edb", edb, 1);
      end
      if (e == 5) chk("rel_eda_drop", eda, 0);
    end
    flt = 4'd3; ina = 1'b0; inb = 1'b0;
    repeat (12) step();
    ina = 1'b1;
    repeat (3) step();
    ina = 1'b0;
    hi = 0;
    repeat (12) begin
      step();
      hi |= int'(oua);
    end
    chk("glitch_low", hi, 0);
    ina = 1'b1;
    ecnt = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      ecnt += int'(eda);
      if (e == 4) ina = 1'b0;
      if (e == 6) chk("pass_e6", oua, 0);
      if (e == 7) chk("pass_e7", oua, 1);
    end
    chk("pass_edges", ecnt, 1);
    flt = 4'd10;
    repeat (20) step();
    chk("thr_idle", oua, 0);
    ina = 1'b1;
    repeat (8) step();
    flt = 4'd2;
    step();
    chk("thr_e9", oua, 0);
    step();
    chk("thr_e10", oua, 1);
    chk("thr_e10_eda", eda, 1);
`ifdef FCIN_PRESCALE_EN
    ina = 1'b0; flt = '0; pdv = 3'd3; clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (8) step();
    ecnt = 0; hi = 0; t0 = -1; t1 = -1;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 8; j++) begin
        ina = j < 4;
        step();
        ecnt += int'(eda);
        hi |= int'(oub);
        if (eda) begin
          if (t0 < 0) t0 = cyc;
          else if (t1 < 0) t1 = cyc;
        end
      end
    chk("pre_pulses", ecnt, 4);
    chk("pre_period", t1 - t0, 64);
    chk("pre_oub", hi, 0);
    pdv = 3'd1; ina = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (6) step();
    ina = 1'b1;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    chk("clr_e4", oua, 0);
    step();
    chk("clr_e5", oua, 0);
    ina = 1'b0;
    repeat (4) step();
    ina = 1'b1;
    ecnt = 0;
    repeat (5) begin
      step();
      ecnt += int'(eda);
    end
    chk("clr_next_eda", ecnt, 1);
    chk("clr_next_oua", oua, 1);
`endif
    ra = 0; rb = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) flt = fs'($urandom_range(0, 5));
      if (i % 250 == 125) pdv = 3'($urandom_range(0, 7));
      if (ra == 0) begin
        ina = ~ina;
        ra = $urandom_range(1, 2 * int'(flt) + 4);
      end
      if (rb == 0) begin
        inb = ~inb;
        rb = $urandom_range(1, 2 * int'(flt) + 4);
      end
      ra--;
      rb--;
      clr = $urandom_range(0, 63) == 0;
      rst = $urandom_range(0, 999) == 0;
      step();
    end
    rst = 1'b0; clr = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fcin.md
# fcin

Input conditioning front end for the frequency meter's two measurement channels. It takes the raw asynchronous inputs `ina`/`inb`, synchronises them into the `clk` domain, rejects glitches shorter than a programmable number of clocks, and optionally divides each channel by a power of two. It feeds clean, registered levels and one-cycle rising-edge strobes straight into the counter core's `ina`/`inb` inputs.

## Interface

- `flt_size`, default 4: width of the glitch-filter threshold and per-channel filter counter.
- `pre_size`, default 7: width of the per-channel prescaler counter; the maximum division is 2^`pre_size`.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ina`  in  1  raw channel A input, asynchronous to `clk`.
- `inb`  in  1  raw channel B input, asynchronous to `clk`.
- `clr`  in  1  synchronous clear of both prescaler counters. The filter state is not touched.
- `flt`  in  `flt_size`  filter threshold. A change is accepted after `flt`+1 consecutive disagreeing samples; `flt`=0 means no filtering.
- `pdv`  in  3  prescaler select: divide by 2^`pdv`. 0 = pass-through. Values above `pre_size` are clamped to `pre_size`.
- `oua`  out  1  conditioned channel A level, registered.
- `oub`  out  1  conditioned channel B level, registered.
- `eda`  out  1  one-clock pulse on each rising edge of `oua`.
- `edb`  out  1  one-clock pulse on each rising edge of `oub`.

## Operation

Both channels are identical and independent. Per channel, the pipeline is:

- **Synchroniser:** two flops, `s1` <= in, then `s2` <= `s1`.
- **Filter**, with filtered level `f` and counter `c`:
  - if `s2` == `f`: `c` <= 0;
  - else if `c` >= `flt`: `f` <= `s2`, `c` <= 0;
  - else: `c` <= `c`+1.
  - `>=` (not `==`) makes lowering `flt` mid-count take effect at once, with no wrap-around.
- **Prescaler** counter `p` (`pre_size` bits):
  - `p` increments, wrapping modulo 2^`pre_size`, on the same edge where `f` goes 0->1.
  - The selected level `sel` is `f` when `pdv`=0, otherwise `p[pdv-1]`.
- **Output stage:** `oua` <= `sel`; `eda` <= `sel` & !`oua`.
- **`clr`:** sets `p` <= 0.
  - If `clr` and an `f` rise coincide, `clr` wins and `p` = 0.
  - The output stage then follows the new `sel` on the next edge. A high output falls and produces no pulse.
- **`pdv` change:** takes effect on the next edge with no glitch protection. Software asserts `clr` after changing `pdv`.
- **Width rule:** `pdv` is compared as an unsigned 3-bit value. With `pre_size` < 7, `pdv` > `pre_size` selects `p[pre_size-1]`.

## Timing

- **Reset values:** with `rst`=1 on an edge, `s1`, `s2`, `f`, `c`, `p`, `oua`, `oub`, `eda` and `edb` are all 0 after that edge. `rst` overrides `clr` and everything else.
- **Reset mid-operation:** a pulse in flight is dropped. The first `oua` rise after reset still produces an `eda` pulse.
- **Latency** from the first rising edge that samples the new input level to the `oua`/`eda` update: 4+`flt` edges when `pdv`=0.
  - A rise sampled at edge 1 gives `s2` at edge 2, `f` at edge 3+`flt`, and `oua`/`eda` at edge 4+`flt`.
- **Prescaled channels:** `oua` toggles once every 2^(`pdv`-1) rises of `f`.
  - `p[pdv-1]` updates on the `f`-rise edge, and `oua` follows one edge later.
- **Minimum pulse width passed:** a high or low phase must persist for `flt`+1 consecutive `s2` samples. Anything shorter leaves `f` unchanged and does not resume counting later: any agreeing sample resets `c`.
- **`eda`/`edb`:** high for exactly one clock and never on two consecutive clocks. Maximum output edge rate is `clk`/2.

## Configuration

- **`FCIN_PRESCALE_EN` defined:** prescaler counters and `pdv` mux are built as described above.
- **`FCIN_PRESCALE_EN` undefined:**
  - no prescaler logic is built;
  - `pdv` and `clr` are ignored (ports remain);
  - `sel` = `f`, so behaviour equals `pdv`=0 in all cases.

## Test plan

- **Reset:** hold `rst`=1 for 3 clocks with `ina`=`inb`=1 -> all outputs 0 during reset. With `flt`=0 and `pdv`=0, `oua`/`oub`/`eda`/`edb` go to 1 at the 4th edge after release. `eda` is 0 on the following edge.
- **Glitch rejection:** `flt`=3, `pdv`=0; `ina` high for 3 clocks, then low -> `oua` stays 0. `ina` high for 4 clocks -> `oua` rises 7 edges after the first sampling edge, and `eda` pulses once.
- **Prescale:** `flt`=0, `pdv`=3; `ina` = 32 clean periods of 8 clocks -> `oua` has period 64 clocks, exactly 4 `eda` pulses, and `oub` is unaffected.
- **Threshold lowered mid-count:** `flt`=10; `ina` rises; after `c` reaches 6, set `flt`=2 -> `f` changes on the next edge with no wrap-around.
- **Clear collision:** `pdv`=1; assert `clr` on the same edge that `f` rises -> `p`=0 and `oua` stays/goes 0. The next `f` rise sets `oua`=1 with an `eda` pulse.
- **Build without `FCIN_PRESCALE_EN`, `pdv`=5:** output timing is identical to the `pdv`=0 run with the macro defined.
